// File: rtl/multicycle_data_path_pkg.sv
// multicycle_data_path_pkg: opcodes, FSM state encoding and ALU control for the multi-cycle datapath.
// DP_BEQ_EN turns opcode 0100 into a compare-and-branch; otherwise it decodes as a NOP.
package multicycle_data_path_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
`ifdef DP_BEQ_EN
    localparam logic BEQ_EN = 1'b1;
`else
    localparam logic BEQ_EN = 1'b0;
`endif
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {ALU_NONE, ALU_ADD, ALU_SUB, ALU_PASS} alu_ctl_t;
    typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_BR} pc_sel_t;

    function automatic alu_ctl_t alu_ctl_of(input logic [3:0] op);
        return (op == OP_ADD || op == OP_ADDI) ? ALU_ADD :
               (op == OP_LW || op == OP_SW)    ? ALU_PASS :
               (BEQ_EN && op == OP_BEQ)        ? ALU_SUB : ALU_NONE;
    endfunction
endpackage

// File: rtl/multicycle_data_path_if.sv
// multicycle_data_path_if: instruction ROM / data RAM handshakes plus datapath status outputs.
interface multicycle_data_path_if #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 9
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ready;
    logic [15:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] alu_result;
    logic              overflow;
    logic              retire;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               opcode, alu_result, overflow, retire,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               opcode, alu_result, overflow, retire,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/multicycle_data_path_ctrl.sv
// multicycle_data_path_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer emitting memory requests,
// register write enable, retire pulse and PC select.
module multicycle_data_path_ctrl
    import multicycle_data_path_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_imem_ready,
    input  logic       i_dmem_ready,
    input  logic [3:0] i_op,
    input  logic       i_taken,
    output state_t     o_state,
    output logic       o_imem_req,
    output logic       o_dmem_req,
    output logic       o_dmem_we,
    output logic       o_reg_we,
    output logic       o_retire,
    output pc_sel_t    o_pc_sel
);
    state_t r_state, w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // imem_req is masked by rst_n so every output reads 0 while reset is held
    always_comb begin
        w_next     = r_state;
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_reg_we   = 1'b0;
        o_retire   = 1'b0;
        o_pc_sel   = PC_HOLD;
        case (r_state)
            S_FETCH: begin
                o_imem_req = rst_n;
                w_next     = i_imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                w_next   = (i_op == OP_LW || i_op == OP_SW)    ? S_MEM :
                           (i_op == OP_ADD || i_op == OP_ADDI) ? S_WB : S_FETCH;
                o_retire = (w_next == S_FETCH);
                o_pc_sel = (w_next != S_FETCH) ? PC_HOLD : i_taken ? PC_BR : PC_INC;
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = (i_op == OP_SW);
                if (i_dmem_ready) begin
                    w_next   = o_dmem_we ? S_FETCH : S_WB;
                    o_retire = o_dmem_we;
                    o_pc_sel = o_dmem_we ? PC_INC : PC_HOLD;
                end
            end
            S_WB: begin
                o_reg_we = 1'b1;
                o_retire = 1'b1;
                o_pc_sel = PC_INC;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign o_state = r_state;
endmodule

// File: rtl/multicycle_data_path.sv
// multicycle_data_path: multi-cycle add/addi/lw/sw(/beq) datapath with stallable ROM/RAM handshakes.
// Define DP_BEQ_EN to execute opcode 0100 as BEQ; by default it retires as a NOP.
module multicycle_data_path
    import multicycle_data_path_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 9
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_data_path_if.master dp
);
    logic [15:0]       r_ir;
    logic [3:0]        r_op;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_a, r_b, r_alu, r_ld;
    logic              r_ovf;
    logic [DATA_W-1:0] r_regs [8];
    state_t            w_state;
    pc_sel_t           w_pc_sel;
    alu_ctl_t          w_ctl;
    logic              w_reg_we, w_taken, w_ovf;
    logic [DATA_W-1:0] w_imm, w_opb, w_sum, w_alu;
    logic [PC_W-1:0]   w_off;

    multicycle_data_path_ctrl u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_imem_ready (dp.imem_ready),
        .i_dmem_ready (dp.dmem_ready),
        .i_op         (r_op),
        .i_taken      (w_taken),
        .o_state      (w_state),
        .o_imem_req   (dp.imem_req),
        .o_dmem_req   (dp.dmem_req),
        .o_dmem_we    (dp.dmem_we),
        .o_reg_we     (w_reg_we),
        .o_retire     (dp.retire),
        .o_pc_sel     (w_pc_sel)
    );

    // BEQ reuses the subtract path; w_ctl is only ALU_SUB when the branch is enabled
    always_comb begin
        w_ctl   = alu_ctl_of(r_op);
        w_imm   = DATA_W'(r_ir[8:0]);
        w_opb   = (r_op == OP_ADD) ? r_b : w_imm;
        w_sum   = r_a + w_opb;
        w_ovf   = (r_a[DATA_W-1] == w_opb[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
        w_alu   = (w_ctl == ALU_ADD)  ? w_sum :
                  (w_ctl == ALU_SUB)  ? r_a - r_b :
                  (w_ctl == ALU_PASS) ? w_imm : r_alu;
        w_taken = (w_ctl == ALU_SUB) && (r_a == r_b);
        w_off   = PC_W'($signed(r_ir[5:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir   <= '0;
            r_op   <= '0;
            r_pc   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_alu  <= '0;
            r_ld   <= '0;
            r_ovf  <= 1'b0;
            r_regs <= '{default: '0};
        end else begin
            if (w_state == S_FETCH && dp.imem_ready) r_ir <= dp.imem_rdata;
            if (w_state == S_DECODE) begin
                r_op <= r_ir[15:12];
                r_a  <= r_regs[r_ir[11:9]];
                r_b  <= r_regs[r_ir[8:6]];
            end
            if (w_state == S_EXEC) r_alu <= w_alu;
            if (w_state == S_EXEC && w_ctl == ALU_ADD) r_ovf <= w_ovf;
            if (w_state == S_MEM && dp.dmem_ready) r_ld <= dp.dmem_rdata;
            if (w_reg_we) r_regs[r_ir[11:9]] <= (r_op == OP_LW) ? r_ld : r_alu;
            r_pc <= (w_pc_sel == PC_BR)  ? r_pc + w_off :
                    (w_pc_sel == PC_INC) ? r_pc + PC_W'(1) : r_pc;
        end
    end

    assign dp.imem_addr  = r_pc;
    assign dp.dmem_addr  = r_ir[DMEM_AW-1:0];
    assign dp.dmem_wdata = r_a;
    assign dp.opcode     = r_op;
    assign dp.alu_result = r_alu;
    assign dp.overflow   = r_ovf;
endmodule
